// File: rtl/req_capture_pkg.sv
// req_capture_pkg: shared constants and the priority-pick helper for req_capture
package req_capture_pkg;
   localparam int N_REQ         = 7;
   localparam int DB_CYCLES_DEF = 4;
   localparam int CNT_W         = $clog2(DB_CYCLES_DEF + 1);
   function automatic logic [N_REQ-1:0] hi_bit(input logic [N_REQ-1:0] v);
      logic [N_REQ-1:0] m;
      m = '0;
      for (int i = 0; i < N_REQ; i++) if (v[i]) m = N_REQ'(1) << i;
      return m;
   endfunction
endpackage

// File: rtl/req_debounce_ch.sv
// req_debounce_ch: one request line -- 2-flop sync, debounce counter, rising-edge detect
module req_debounce_ch
   import req_capture_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
   logic [1:0]    sync;
   logic          db;
   logic [CW-1:0] cnt;
   logic          flip;
   assign flip = (sync[1] != db) && (cnt == LAST);
   assign rise = flip && sync[1];
   // synchronize, count consecutive disagreeing samples, accept the new level after DB_CYCLES
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync <= '0;
         db   <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[0], raw};
         db   <= flip ? sync[1] : db;
         cnt  <= (sync[1] == db || flip) ? '0 : cnt + 1'b1;
      end
endmodule

// File: rtl/req_capture.sv
// req_capture: debounced request capture with ack-by-priority, sync clear and sticky overrun
module req_capture
   import req_capture_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int N_REQ     = req_capture_pkg::N_REQ
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] raw,
   input  logic             ack,
   input  logic             clr,
   output logic [N_REQ-1:0] a,
   output logic             enable,
   output logic             overrun
);
   logic [1:0]       rst_sync;
   logic             rst_i;
   logic [N_REQ-1:0] rise, pending, take;
   // assert reset at once, release it two edges later so no flop sees a partial release
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rst_sync <= '0;
      else rst_sync <= {rst_sync[0], 1'b1};
   assign rst_i = rst_sync[1];
   for (genvar i = 0; i < N_REQ; i++) begin : g_ch
      req_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
         .clk  (clk),
         .rst_n(rst_i),
         .raw  (raw[i]),
         .rise (rise[i])
      );
   end
   assign take = ack ? hi_bit(pending) : '0;
   // clr wins; a rise on a bit being acked keeps it set without flagging overrun
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         pending <= '0;
         overrun <= 1'b0;
      end else begin
         pending <= clr ? '0 : (pending & ~take) | rise;
         overrun <= clr ? 1'b0 : overrun | (|(rise & pending & ~take));
      end
   assign a      = pending;
   assign enable = ~|pending;
endmodule

// File: tb/tb_req_capture.sv
// tb_req_capture: randomized + directed scoreboard bench for req_capture
module tb_req_capture;
   localparam int DB = 4;
   logic       clk = 1'b0, rst_n = 1'b0, ack = 1'b0, clr = 1'b0;
   logic [6:0] raw = '0, a;
   logic       enable, overrun;
   int         n_cmp = 0, n_bad = 0;

   req_capture #(.DB_CYCLES(DB), .N_REQ(7)) dut (
      .clk(clk), .rst_n(rst_n), .raw(raw), .ack(ack), .clr(clr),
      .a(a), .enable(enable), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // reference model: a line's accepted level flips once its last DB synchronized
   // samples all disagree with it; requests are latched on accepted 0->1 changes
   logic [6:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_pend = '0;
   logic       m_ov = 1'b0;
   int         rel = 0;
   logic [6:0] hist[$];
   logic [7:0] expq[$];
   logic [6:0] flip, rise, take;
   logic       all_diff;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_ov = 1'b0;
         hist.delete();
         rel = 0;
      end else if (rel < 2) begin
         rel++;
      end else begin
         hist.push_back(m_s2);
         if (hist.size() > DB) void'(hist.pop_front());
         flip = '0;
         if (hist.size() == DB)
            for (int b = 0; b < 7; b++) begin
               all_diff = 1'b1;
               foreach (hist[j]) if (hist[j][b] == m_db[b]) all_diff = 1'b0;
               flip[b] = all_diff;
            end
         rise = flip & ~m_db;
         m_db = m_db ^ flip;
         m_s2 = m_s1;
         m_s1 = raw;
         take = '0;
         if (ack) for (int b = 0; b < 7; b++) if (m_pend[b]) take = 7'(1) << b;
         if (clr) begin
            m_pend = '0;
            m_ov   = 1'b0;
         end else begin
            m_ov   = m_ov | (|(rise & m_pend & ~take));
            m_pend = (m_pend & ~take) | rise;
         end
      end
      expq.push_back({m_ov, m_pend});
   end

   // monitor: compare the DUT against the oldest expected state, just after each edge
   logic [7:0] e;
   always @(posedge clk) begin
      #1;
      n_cmp++;
      if (expq.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = expq.pop_front();
         if (a !== e[6:0] || enable !== (e[6:0] == 7'h00) || overrun !== e[7]) begin
            n_bad++;
            $display("FAIL edge_state t=%0t got a=%h en=%b ov=%b required a=%h en=%b ov=%b",
                     $time, a, enable, overrun, e[6:0], e[6:0] == 7'h00, e[7]);
         end
      end
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      wait_n(1);
      ack = 1'b0;
   endtask

   task automatic chk_rst();
      n_cmp++;
      if (a !== 7'h00 || enable !== 1'b1 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset got a=%h en=%b ov=%b required a=00 en=1 ov=0", a, enable, overrun);
      end
   endtask

   initial begin
      #2 chk_rst();
      wait_n(3);
      rst_n = 1'b1;
      // single held line
      raw = 7'h04; wait_n(12);
      raw = 7'h00; wait_n(8);
      pulse_ack(); wait_n(2);
      // short glitch on bit 3
      raw = 7'h08; wait_n(3);
      raw = 7'h00; wait_n(8);
      // pending 0x45 drained by acks, one extra ack on empty
      raw = 7'h45; wait_n(8);
      raw = 7'h00; wait_n(8);
      repeat (4) begin pulse_ack(); wait_n(2); end
      // re-press without ack -> overrun, then clr
      raw = 7'h20; wait_n(8);
      raw = 7'h00; wait_n(8);
      raw = 7'h20; wait_n(8);
      raw = 7'h00; wait_n(8);
      clr = 1'b1; wait_n(1);
      clr = 1'b0; wait_n(2);
      // ack lands on the same edge as a new rise of bit 5
      raw = 7'h20; wait_n(8);
      raw = 7'h00; wait_n(8);
      raw = 7'h20; wait_n(5);
      pulse_ack(); wait_n(3);
      raw = 7'h00; wait_n(8);
      clr = 1'b1; wait_n(1);
      clr = 1'b0;
      // reset while everything is pending and counters are moving
      raw = 7'h7F; wait_n(8);
      raw = 7'h15; wait_n(2);
      #2 rst_n = 1'b0;
      #1 chk_rst();
      wait_n(2);
      chk_rst();
      rst_n = 1'b1;
      wait_n(12);
      // randomized traffic with occasional clr and reset pulses
      for (int c = 0; c < 1500; c++) begin
         raw   = raw ^ (7'($urandom) & 7'($urandom) & 7'($urandom) & 7'($urandom));
         ack   = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 79) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         wait_n(1);
      end
      ack = 1'b0; clr = 1'b0; rst_n = 1'b1;
      wait_n(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/req_capture.md
REQ_CAPTURE -- requirements
Module: req_capture

Interface
REQ-001: Parameter DB_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples needed to accept a level change (legal range 2..15).
REQ-002: Parameter N_REQ, default 7, SHALL set the number of request lines; the only supported value is 7.
REQ-003: clk  input  1  SHALL be the single clock; every flop in the block SHALL be clocked on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005: raw  input  7  SHALL carry asynchronous request lines (buttons or external sources); bit 6 is the highest priority.
REQ-006: ack  input  1  SHALL be a single-cycle pulse meaning "the consumer took the current highest-priority request".
REQ-007: clr  input  1  SHALL be a synchronous clear of all pending requests and of overrun.
REQ-008: a  output  7  SHALL present the pending-request vector that feeds the 7-to-3 priority encoder.
REQ-009: enable  output  1  SHALL be high when no request is pending; in that state the downstream encoder drives hi-Z.
REQ-010: overrun  output  1  SHALL be a sticky flag meaning a request arrived on a line that was already pending.

Function
REQ-011: Each raw[i] SHALL pass through a two-flop synchronizer whose second-stage output is s[i].
REQ-012: Each channel SHALL hold a debounced level db[i] and a counter cnt[i] of width clog2(DB_CYCLES+1).
REQ-013: When s[i]==db[i], the channel SHALL load cnt[i] with 0.
REQ-014: When s[i]!=db[i] and cnt[i]<DB_CYCLES-1, the channel SHALL increment cnt[i].
REQ-015: When s[i]!=db[i] and cnt[i]==DB_CYCLES-1, the channel SHALL load db[i] with s[i] and cnt[i] with 0.
REQ-016: A glitch shorter than DB_CYCLES synchronized cycles SHALL leave db[i] unchanged and return cnt[i] to 0.
REQ-017: On the same edge that db[i] goes from 0 to 1, the block SHALL set pending[i].
REQ-018: A 1-to-0 transition of db[i] SHALL have no effect on pending[i].
REQ-019: Latency: if raw[i] is high and stable from rising edge k onward, a[i] SHALL go high after edge k+DB_CYCLES+1, i.e. on the (DB_CYCLES+2)th sampling edge.
REQ-020: Output a SHALL equal pending directly from registers, with no combinational path from raw.
REQ-021: enable SHALL equal the NOR of all pending bits, decoded from registers.
REQ-022: An ack with pending nonzero SHALL clear only the highest-index set bit of pending on the next edge.
REQ-023: An ack with pending all-zero SHALL be ignored, with no state change.
REQ-024: If a rise event and an ack clear hit the same bit on the same edge, the bit SHALL remain set and overrun SHALL NOT set.
REQ-025: A rise event on a bit that is set and not being cleared that edge SHALL set overrun; the pending bit SHALL stay 1.
REQ-026: Rise events on different bits in the same cycle SHALL all be captured.
REQ-027: clr SHALL take priority over ack and over rise events: on that edge, pending and overrun go to 0.
REQ-028: clr SHALL NOT reset the synchronizers, db, or cnt, so a held line does not re-trigger after clr.

Reset
REQ-029: While rst_n is low, synchronizers, db, cnt, pending and overrun SHALL all be 0, giving a=7'b0, enable=1, overrun=0.
REQ-030: Reset deassertion SHALL be synchronized inside the block.
REQ-031: The first state update after reset release SHALL occur no earlier than the second rising edge after rst_n goes high.
REQ-032: A line held high through reset SHALL be captured as a new request after release, after the REQ-019 latency.
REQ-033: Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-034: A shared package SHALL hold N_REQ=7, the DB_CYCLES default, and the counter-width constant.
REQ-035: The per-channel synchronizer, debounce counter and rise detect SHALL be one sub-module, req_debounce_ch, instantiated 7 times.
REQ-036: The pending, ack, clr and overrun logic SHALL reside in req_capture itself.

Verification
REQ-037: After reset release, raw=7'h04 held -> a=7'h04 and enable=0 exactly 6 edges later (DB_CYCLES=4); before that, a=0 and enable=1.
REQ-038: raw[3] pulsed high for 3 synchronized cycles -> a stays 7'h00 and enable stays 1.
REQ-039: Pending 7'h45 with three ack pulses -> a steps 7'h05, then 7'h01, then 7'h00 with enable=1; a fourth ack leaves all state unchanged.
REQ-040: Pending bit 5 set, raw[5] released, debounced low, then pressed again without ack -> overrun=1 and a[5] stays 1; clr -> a=0 and overrun=0.
REQ-041: ack on pending 7'h20 on the same edge that a new rise on bit 5 completes -> a=7'h20 and overrun=0.
REQ-042: rst_n pulsed low with pending 7'h7F and counters mid-flight -> a=0, enable=1, overrun=0 asynchronously while rst_n is low.
